// File: rtl/conv3x3_sched.sv
// Sequencer for the 3x3 convolution core: kernel load, credit-gated window issue
// in row-major order, and a tagged delay line that labels each core result.
module conv3x3_sched #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int CORE_LAT  = 4,
  parameter int CRD_DEPTH = 8,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          kload_en,
  output logic [3:0]    kload_idx,
  output logic          win_valid,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  input  logic          credit_ret,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KLOAD = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 3);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 3);
  localparam logic [7:0]    CRD_INIT = 8'(CRD_DEPTH);

  logic [2:0]          state;
  logic [3:0]          kidx;
  logic [CW-1:0]       row;
  logic [CW-1:0]       col;
  logic [7:0]          credits;
  logic [CORE_LAT-1:0] dl_v;
  logic [CW-1:0]       dl_row [CORE_LAT];
  logic [CW-1:0]       dl_col [CORE_LAT];

  logic run;
  logic issue;
  logic start_ok;
  logic kill;
  logic drain_empty;

  // Flow control: win_valid has no ready. A window is issued in every RUN
  // cycle with credits>0; credits count free downstream slots and credit_ret
  // returns one slot per pulse, so the consumer can never be overrun.
  assign run      = (state == S_RUN);
  assign issue    = run && (credits != 8'd0);
  assign start_ok = (state == S_IDLE) && start;
  assign kill     = abort && (state != S_IDLE);

  // DRAIN may leave once the line will be empty after this cycle's shift,
  // so done lands the cycle right after the last result.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < CORE_LAT - 1; i++) begin
      if (dl_v[i]) drain_empty = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      kidx  <= 4'd0;
      row   <= '0;
      col   <= '0;
    end else if (kill) begin
      state <= S_IDLE;
      kidx  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_KLOAD;
            kidx  <= 4'd0;
            row   <= '0;
            col   <= '0;
          end
        end
        S_KLOAD: begin
          if (kidx == 4'd8) begin
            state <= S_RUN;
            kidx  <= 4'd0;
          end else begin
            kidx <= kidx + 4'd1;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) state <= S_DRAIN;
              else                 row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_empty) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A return arriving while the counter is already full means the consumer
  // sent more credits than it was given.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= CRD_INIT;
      err     <= 1'b0;
    end else if (start_ok) begin
      credits <= CRD_INIT;
      err     <= 1'b0;
    end else if (issue && !credit_ret) begin
      credits <= credits - 8'd1;
    end else if (credit_ret && !issue) begin
      if (credits >= CRD_INIT) err     <= 1'b1;
      else                     credits <= credits + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v <= '0;
      for (int i = 0; i < CORE_LAT; i++) begin
        dl_row[i] <= '0;
        dl_col[i] <= '0;
      end
    end else begin
      for (int i = CORE_LAT - 1; i > 0; i--) begin
        dl_v[i]   <= dl_v[i-1];
        dl_row[i] <= dl_row[i-1];
        dl_col[i] <= dl_col[i-1];
      end
      dl_v[0]   <= issue;
      dl_row[0] <= row;
      dl_col[0] <= col;
      if (kill) dl_v <= '0;
    end
  end

  assign kload_en  = (state == S_KLOAD);
  assign kload_idx = kload_en ? kidx : 4'd0;
  assign win_valid = issue;
  assign win_row   = run ? row : '0;
  assign win_col   = run ? col : '0;
  assign out_valid = dl_v[CORE_LAT-1];
  assign out_row   = out_valid ? dl_row[CORE_LAT-1] : '0;
  assign out_col   = out_valid ? dl_col[CORE_LAT-1] : '0;
  assign busy      = (state == S_KLOAD) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: doc/conv3x3_sched.md
Name: conv3x3_sched

Overview:
- Sequencer for the 3x3 floating-point convolution core.
- On start, it walks the kernel-load phase, then issues one window request per output position of an IMG_W x IMG_H feature map (valid convolution, no padding, stride 1), in row-major order.
- Tracks core latency with a tagged delay line, so each result is flagged with its (row, col) coordinate.
- Gates issue with a credit counter that mirrors free space in the downstream result buffer.

Parameters:
- IMG_W, 28, input map width in pixels (>=3)
- IMG_H, 28, input map height in pixels (>=3)
- CORE_LAT, 4, cycles from window issue to core result (>=1)
- CRD_DEPTH, 8, downstream result-buffer slots = initial credits (1..255)
- CW, 16, coordinate width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a frame when sampled in IDLE
- abort  in  1  synchronous; cancels the frame
- kload_en  out  1  kernel register write strobe
- kload_idx  out  4  kernel word index 0..8
- win_valid  out  1  window issue; drives core Valid_In and window fetch
- win_row  out  CW  top-left row of the issued window
- win_col  out  CW  top-left column of the issued window
- out_valid  out  1  core result valid for writeback
- out_row  out  CW  coordinate tag of the result
- out_col  out  CW  coordinate tag of the result
- credit_ret  in  1  downstream freed one slot
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- err  out  1  sticky credit-overflow flag

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; credits=CRD_DEPTH; delay line cleared; err=0.
- FSM states and transitions:
  - IDLE -> KLOAD on start=1. Also reloads credits=CRD_DEPTH and clears err.
  - KLOAD: kload_en=1 for exactly 9 cycles, kload_idx=0,1,..,8; then -> RUN.
  - RUN: win_valid=1 in any cycle where credits>0.
    - The issued coordinate advances only on issue: col 0..IMG_W-3, then col=0 and row+1, up to row IMG_H-3.
    - After issue of (IMG_H-3, IMG_W-3) -> DRAIN.
    - Total issues per frame = (IMG_W-2)*(IMG_H-2).
  - DRAIN: no issue. When the delay line holds no valid entry -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in KLOAD, RUN and DRAIN; 0 in IDLE and DONE.
- start while not in IDLE is ignored.
- win_row/win_col hold the current coordinate whenever in RUN; they are 0 outside RUN. Their value is meaningful only when win_valid=1.
- Delay line: a CORE_LAT-deep shift of {valid,row,col}, advancing every cycle (no stall).
  - out_valid/out_row/out_col appear exactly CORE_LAT cycles after the matching win_valid.
- Credits (width 8):
  - Issue alone: -1.
  - credit_ret alone: +1.
  - Both in the same cycle: unchanged.
  - credit_ret with credits==CRD_DEPTH and no issue: credits unchanged, err<=1 (sticky until the next accepted start or reset).
  - credit_ret is honoured in every state, including IDLE.
- abort (any non-IDLE state): next state IDLE; delay line valid bits cleared (no out_valid afterwards); kload_en=0; no done pulse; credits reloaded on the next start.
- Reset asserted mid-frame: immediate return to reset values; no done.

Test Plan:
- IMG_W=5, IMG_H=4, CORE_LAT=4, CRD_DEPTH=8, credit_ret tied to out_valid -> sequence is:
  - start at cycle 0;
  - kload_idx 0..8 on cycles 1-9;
  - 6 consecutive win_valid at cycles 10-15, coords (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - out_valid at cycles 14-19 with the same tags;
  - done at cycle 20; busy low from cycle 20.
- Same config, credit_ret held 0, CRD_DEPTH=2 -> exactly 2 issues ((0,0),(0,1)), then win_valid stays 0. A single credit_ret pulse yields exactly one further issue, (0,2).
- credit_ret and issue in the same cycle with credits=1 -> credits remain 1 and issue continues back-to-back.
- In IDLE with credits=8, pulse credit_ret -> err=1, credits=8. A following start clears err.
- abort asserted in RUN after 3 issues -> IDLE next cycle; no out_valid in the following CORE_LAT cycles; no done. A new start reruns the full frame from (0,0).
- rst pulled low during DRAIN -> all outputs 0 asynchronously. start during KLOAD is ignored: kload_idx still counts 0..8 once.
